// File: rtl/ahb_lite_fifo_slave.sv
// AHB-Lite responder: DATA writes push into a FIFO drained by a local consumer;
// a write that stays blocked on a full FIFO is failed with ERROR after TIMEOUT wait cycles.
module ahb_lite_fifo_slave #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic        q_valid,
  output logic [31:0] q_data,
  input  logic        q_ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_WAIT,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic          write_q, write_d;
  logic [2:0]    size_q, size_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [31:0]   mem_q [DEPTH];

  logic        full;
  logic        empty;
  logic        addr_valid;
  logic        addr_bad;
  logic        is_data_q;
  logic        wr_data;
  logic        accept;
  logic        push;
  logic        pop;
  logic [31:0] push_data;
  logic [31:0] status;
  logic        unused_inputs;

  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HADDR[31:16], HTRANS[0]};

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign addr_valid = HSEL & HREADY & HTRANS[1];
  assign addr_bad   = (HSIZE > 3'd2) | (HADDR[15:3] != '0);
  assign is_data_q  = (addr_q[15:2] == '0);
  assign wr_data    = write_q & is_data_q;

  assign q_valid = ~empty;
  assign q_data  = empty ? '0 : mem_q[rptr_q];
  assign pop     = q_valid & q_ready;
  assign status  = {16'h0000, 8'(count_q), 6'b000000, full, empty};
  assign HRDATA  = (state_q == S_DATA && !write_q) ? (is_data_q ? q_data : status) : '0;

  // The first data-phase cycle of a blocked write already counts as wait cycle 1,
  // so WAIT is entered with wcnt = 2 and holds the index of the current wait cycle.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    wcnt_d    = wcnt_q;
    push      = 1'b0;
    accept    = 1'b0;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      S_IDLE: accept = 1'b1;
      S_DATA: begin
        if (wr_data && full) begin
          HREADYOUT = 1'b0;
          if (TIMEOUT == 1) begin
            state_d = S_ERR1;
          end else begin
            state_d = S_WAIT;
            wcnt_d  = WW'(2);
          end
        end else begin
          push   = wr_data;
          accept = 1'b1;
        end
      end
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (!full) begin
          state_d = S_DATA;
        end else if (wcnt_q == WW'(TIMEOUT)) begin
          state_d = S_ERR1;
        end else begin
          wcnt_d = wcnt_q + WW'(1);
        end
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        HRESP  = 1'b1;
        accept = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      if (addr_valid) begin
        state_d = addr_bad ? S_ERR1 : S_DATA;
        addr_d  = HADDR[15:0];
        write_d = HWRITE;
        size_d  = HSIZE;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    push_data = HWDATA;
    case (size_q)
      3'd0: begin
        case (addr_q[1:0])
          2'd0:    push_data = {24'h000000, HWDATA[7:0]};
          2'd1:    push_data = {24'h000000, HWDATA[15:8]};
          2'd2:    push_data = {24'h000000, HWDATA[23:16]};
          default: push_data = {24'h000000, HWDATA[31:24]};
        endcase
      end
      3'd1:    push_data = addr_q[1] ? {16'h0000, HWDATA[31:16]} : {16'h0000, HWDATA[15:0]};
      default: push_data = HWDATA;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + AW'(1);
    if (pop)  rptr_d = rptr_q + AW'(1);
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push && !HRESET) begin
      mem_q[wptr_q] <= push_data;
    end
  end

endmodule

// File: doc/ahb_lite_fifo_slave.md
# ahb_lite_fifo_slave

AHB-Lite responder that turns bus writes into a queued command stream for a local consumer. It sits on one decoder select line, behind the AHB-Lite mux, alongside the existing memory slaves. HADDR[15:0] is the in-slave offset. Writes to DATA push into an internal FIFO, and STATUS exposes the fill level. A full FIFO inserts wait states and converts a stuck write into an ERROR response after a bounded timeout.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..128
- TIMEOUT, 16, maximum full-FIFO wait cycles before a write is failed; ≥1
- HCLK  in  1  bus clock; all logic on rising edge
- HRESET  in  1  one clock; reset is synchronous and active-high
- HSEL  in  1  slave select from decoder
- HADDR  in  32  address; [15:0] used
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HBURST, HPROT, HMASTLOCK  in  3/4/1  accepted and ignored
- HTRANS  in  2  IDLE/BUSY/NONSEQ/SEQ
- HREADY  in  1  bus-wide ready from mux
- HWDATA  in  32  write data (data phase)
- HREADYOUT  out  1  this slave's ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  32  read data (data phase)
- q_valid  out  1  FIFO non-empty
- q_data  out  32  FIFO head; 0 when empty
- q_ready  in  1  consumer pop strobe

## Operation
- Address phase is captured on HSEL & HREADY & HTRANS[1]. Registered: offset, write, size, byte lane HADDR[1:0].
- IDLE or BUSY, or unselected: no data phase. The next cycle returns OKAY with zero wait.
- Register map, decoded on HADDR[15:2]:
  - 0x0000 DATA
    - Write: push lane-extracted HWDATA, zero-extended to 32 bits (Byte uses lane HADDR[1:0]; Halfword uses HADDR[1]).
    - Read: peek at the head without popping; returns 0 if empty.
  - 0x0004 STATUS, read-only
    - [0] empty, [1] full, [15:8] count, others 0.
    - Writes are ignored with OKAY.
  - Any other offset, or HSIZE > Word: ERROR response, no side effects.
- FSM states:
  - IDLE: no data phase pending.
  - DATA: single-cycle completion.
  - WAIT: write pending on a full FIFO; counter wcnt runs.
  - ERR1, ERR2: two-cycle ERROR response.
- Transitions:
  - IDLE→DATA on a valid address phase.
  - DATA with DATA-write & full→WAIT.
  - WAIT→DATA-complete when not full.
  - WAIT→ERR1 when wcnt == TIMEOUT.
  - Bad access→ERR1→ERR2→IDLE, or →DATA if a new address phase is accepted in ERR2.
- Push happens on the edge that completes the write data phase (HREADYOUT=1, OKAY). A timed-out write is dropped.
- Pop: on each edge where q_valid & q_ready. Read pointer wraps modulo DEPTH.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full means count == DEPTH at the start of the cycle. A pop in the same cycle does not unblock a waiting write until the next cycle.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, q_valid=0, q_data=0. FSM=IDLE, pointers/count/wcnt=0.
- Reset asserted mid-transfer or mid-wait:
  - FIFO is flushed and the pending write is discarded.
  - Outputs take their reset values on the next edge.
- Reads (both registers) complete with zero wait states. HRDATA is valid in the data phase, driven from the registered offset and current FIFO state. It is 0 outside read data phases.
- Writes to a non-full FIFO: zero wait states. The new entry is visible on q_valid/q_data the cycle after the completing edge.
- Full FIFO:
  - HREADYOUT=0, HRESP=0 for up to TIMEOUT cycles.
  - Then ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
- Wait cycles end in OKAY the first cycle that count < DEPTH is registered. If space appears on wait cycle k ≤ TIMEOUT, that is k wait cycles in total.
- Address phases presented while HREADY=0 are not captured.

## Test plan
- Reset, then write 0x000000FF Word to 0x0000, then read 0x0004 → zero-wait OKAY; q_valid=1, q_data=0xFF next cycle; STATUS=0x00000100.
- Halfword write HWDATA=0xCCCC1234 to offset 0x0002, then Byte write HWDATA=0xAABBCCDD to offset 0x0001 → entries 0x0000CCCC then 0x000000CC.
- With q_ready=0, write DEPTH words, then one more → that write has TIMEOUT (16) wait cycles, then ERR1/ERR2. Count stays 8 and STATUS reads 0x00000802.
- Fill the FIFO, write again, and pulse q_ready on wait cycle 3 → write completes OKAY after 4 wait cycles; count returns to 8 and FIFO order is preserved across pointer wrap.
- Read 0x0010, then write Doubleword to 0x0000 → each gets a two-cycle ERROR with no FIFO change. A back-to-back NONSEQ issued in ERR2 completes normally.
- Assert HRESET during a full-FIFO wait → next edge: HREADYOUT=1, HRESP=0, q_valid=0, STATUS=0x00000001.
